// File: rtl/comm_pkg.sv
// Shared types and constants for the BER tester: FSM states, 4-ASK symbol codes,
// counter widths and the symbol-to-level mapping.
package comm_pkg;

  typedef enum logic {
    ST_ALIGN  = 1'b0,
    ST_LOCKED = 1'b1
  } ber_state_t;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b10;
  localparam logic [1:0] SYM_P3 = 2'b11;

  localparam int LEVEL_W  = 18;
  localparam int LFSR_W   = 15;
  localparam int CNT_W    = 32;
  localparam int WERR_W   = 7;
  localparam int WIN_W    = 16;
  localparam int DLY_W    = 4;
  localparam int HIST_LEN = 16;

  function automatic logic signed [LEVEL_W-1:0] sym_to_level(
    input logic [1:0]                a_sym,
    input logic signed [LEVEL_W-1:0] a_lvl
  );
    logic signed [LEVEL_W-1:0] a3;
    a3 = (a_lvl <<< 1) + a_lvl;
    case (a_sym)
      SYM_M3:  return -a3;
      SYM_M1:  return -a_lvl;
      SYM_P1:  return a_lvl;
      default: return a3;
    endcase
  endfunction

endpackage

// File: rtl/pn4_source.sv
// PN 4-ASK source: 15-bit Fibonacci LFSR (x^15+x^14+1) advanced two steps per strobe.
// sym is the symbol about to be emitted; level is the registered constellation level.
module pn4_source
  import comm_pkg::*;
#(
  parameter logic signed [LEVEL_W-1:0] LEVEL_A = 18'sd16384,
  parameter logic [LFSR_W-1:0]         SEED    = 15'h0001
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sym_clk,
  output logic [1:0]                sym,
  output logic signed [LEVEL_W-1:0] level
);

  logic [LFSR_W-1:0] lfsr;
  logic              b1, b2;

  // b2 is the feedback after one shift, expressed in terms of the current state
  assign b1  = lfsr[14] ^ lfsr[13];
  assign b2  = lfsr[13] ^ lfsr[12];
  assign sym = {b1, b2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr  <= SEED;
      level <= '0;
    end else if (sym_clk) begin
      lfsr  <= {lfsr[12:0], b1, b2};
      level <= sym_to_level(sym, LEVEL_A);
    end
  end

endmodule

// File: rtl/comm_ber_tester.sv
// Closed-loop BER tester: emits a PN 4-ASK stream, slices the returned samples,
// searches the end-to-end symbol delay window by window, then counts symbol errors.
module comm_ber_tester
  import comm_pkg::*;
#(
  parameter logic signed [17:0] LEVEL_A   = 18'sd16384,
  parameter logic signed [17:0] SLICE_T   = 18'sd32768,
  parameter logic [14:0]        SEED      = 15'h0001,
  parameter int                 MAX_DELAY = 15,
  parameter int                 WINDOW    = 64,
  parameter int                 LOCK_ERR  = 2,
  parameter int                 LOSS_ERR  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk,
  input  logic               clear_accum,
  input  logic signed [17:0] rx_in,
  output logic signed [17:0] tx_out,
  output logic               locked,
  output logic [3:0]         delay,
  output logic [31:0]        sym_count,
  output logic [31:0]        err_count
);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [DLY_W-1:0]  DLY_MAX  = DLY_W'(MAX_DELAY);
  localparam logic [WERR_W-1:0] LOCK_TH  = WERR_W'(LOCK_ERR);
  localparam logic [WERR_W-1:0] LOSS_TH  = WERR_W'(LOSS_ERR);

  ber_state_t                       state;
  logic [1:0]                       next_sym;
  logic [HIST_LEN-1:0][1:0]         hist;
  logic [1:0]                       rx_sym;
  logic                             mismatch;
  logic [WIN_W-1:0]                 win_cnt;
  logic [WERR_W-1:0]                win_err, win_err_tot;
  logic                             win_end;

  pn4_source #(
    .LEVEL_A (LEVEL_A),
    .SEED    (SEED)
  ) u_src (
    .clk     (clk),
    .reset   (reset),
    .sym_clk (sym_clk),
    .sym     (next_sym),
    .level   (tx_out)
  );

  // hist[0] takes the symbol being loaded into tx_out, so a zero-delay loopback
  // compares against hist[0] on the following strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        hist <= '0;
    else if (sym_clk) hist <= {hist[HIST_LEN-2:0], next_sym};
  end

  always_comb begin
    rx_sym = SYM_M3;
    if (rx_in >= SLICE_T)       rx_sym = SYM_P3;
    else if (rx_in >= 18'sd0)   rx_sym = SYM_P1;
    else if (rx_in >= -SLICE_T) rx_sym = SYM_M1;
  end

  assign mismatch    = (rx_sym != hist[delay]);
  assign win_end     = (win_cnt == WIN_LAST);
  assign win_err_tot = (mismatch && (win_err != '1)) ? win_err + 1'b1 : win_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ALIGN;
      locked    <= 1'b0;
      delay     <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      sym_count <= '0;
      err_count <= '0;
    end else begin
      if (sym_clk) begin
        if (win_end) begin
          win_cnt <= '0;
          win_err <= '0;
          case (state)
            ST_ALIGN: begin
              if (win_err_tot <= LOCK_TH) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end else begin
                delay <= (delay == DLY_MAX) ? '0 : delay + 1'b1;
              end
            end
            default: begin
              if (win_err_tot > LOSS_TH) begin
                state  <= ST_ALIGN;
                locked <= 1'b0;
              end
            end
          endcase
        end else begin
          win_cnt <= win_cnt + 1'b1;
          win_err <= win_err_tot;
        end
      end

      // clear beats a coincident strobe; the strobe that drops lock is still counted
      if (clear_accum) begin
        sym_count <= '0;
        err_count <= '0;
      end else if (sym_clk && state == ST_LOCKED) begin
        if (sym_count != '1)             sym_count <= sym_count + 1'b1;
        if (mismatch && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comm_ber_tester.sv
// Randomized bench for comm_ber_tester against a list-based behavioural model of
// the PN stream, the channel delay and the window/lock rules.
module tb_comm_ber_tester;

  logic               clk = 1'b0;
  logic               reset, sym_clk, clear_accum;
  logic signed [17:0] rx_in, tx_out;
  logic               locked;
  logic [3:0]         delay;
  logic [31:0]        sym_count, err_count;

  int errors = 0;
  int checks = 0;

  // model state
  int     msym[$];
  int     m_lfsr, m_tx, m_delay, m_widx, m_werr;
  bit     m_locked;
  longint m_sym, m_err;

  always #5 clk = ~clk;

  comm_ber_tester dut (
    .clk         (clk),
    .reset       (reset),
    .sym_clk     (sym_clk),
    .clear_accum (clear_accum),
    .rx_in       (rx_in),
    .tx_out      (tx_out),
    .locked      (locked),
    .delay       (delay),
    .sym_count   (sym_count),
    .err_count   (err_count)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lvl(input int s);
    case (s)
      0:       return -49152;
      1:       return -16384;
      2:       return 16384;
      default: return 49152;
    endcase
  endfunction

  function automatic int slice(input int v);
    if (v >= 32768)       return 3;
    else if (v >= 0)      return 2;
    else if (v >= -32768) return 1;
    return 0;
  endfunction

  // symbol sent d+1 strobes before the upcoming one (00 before any were sent)
  function automatic int past_sym(input int d);
    int idx;
    idx = msym.size() - 1 - d;
    return (idx >= 0) ? msym[idx] : 0;
  endfunction

  // what a d-stage strobe-enabled register chain after tx_out presents now
  function automatic int loop_rx(input int d);
    int idx;
    idx = msym.size() - 1 - d;
    return (idx >= 0) ? lvl(msym[idx]) : 0;
  endfunction

  task automatic model_reset();
    msym.delete();
    m_lfsr = 1; m_tx = 0; m_delay = 0; m_widx = 0; m_werr = 0;
    m_locked = 0; m_sym = 0; m_err = 0;
  endtask

  task automatic model_step(input int rx, input bit clr);
    bit mis;
    int tot, b1, b2;
    mis = (slice(rx) != past_sym(m_delay));
    tot = m_werr + int'(mis);
    if (tot > 127) tot = 127;
    if (clr) begin
      m_sym = 0; m_err = 0;
    end else if (m_locked) begin
      m_sym++;
      if (mis) m_err++;
    end
    if (m_widx == 63) begin
      m_widx = 0; m_werr = 0;
      if (!m_locked) begin
        if (tot <= 2) m_locked = 1;
        else          m_delay  = (m_delay == 15) ? 0 : m_delay + 1;
      end else if (tot > 16) begin
        m_locked = 0;
      end
    end else begin
      m_widx++; m_werr = tot;
    end
    b1 = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
    m_lfsr = ((m_lfsr << 1) | b1) & 32'h7fff;
    b2 = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
    m_lfsr = ((m_lfsr << 1) | b2) & 32'h7fff;
    msym.push_back(b1 * 2 + b2);
    m_tx = lvl(b1 * 2 + b2);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tx_out"},    longint'(tx_out),    longint'(m_tx));
    chk({tag, ".locked"},    longint'(locked),    longint'(m_locked));
    chk({tag, ".delay"},     longint'(delay),     longint'(m_delay));
    chk({tag, ".sym_count"}, longint'(sym_count), m_sym);
    chk({tag, ".err_count"}, longint'(err_count), m_err);
  endtask

  task automatic strobe(input int rx, input bit clr);
    @(negedge clk);
    rx_in = 18'(rx); sym_clk = 1'b1; clear_accum = clr;
    model_step(rx, clr);
    @(negedge clk);
    sym_clk = 1'b0; clear_accum = 1'b0;
    check_all("strobe");
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    int base, n, e, d0, r;
    reset = 1'b1; sym_clk = 1'b0; clear_accum = 1'b0; rx_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;

    // first symbol and direct loopback lock
    strobe(loop_rx(0), 1'b0);
    chk("first_tx", longint'(tx_out), -49152);
    repeat (63) strobe(loop_rx(0), 1'b0);
    chk("lock_direct", longint'(locked), 1);
    chk("lock_direct_dly", longint'(delay), 0);
    repeat (1000) strobe(loop_rx(0), 1'b0);
    chk("direct_syms", longint'(sym_count), 1000);
    chk("direct_errs", longint'(err_count), 0);

    // slicer edge values chosen so a correct slicer sees no error
    base = int'(m_err);
    for (int i = 0; i < 32; i++) begin
      e = past_sym(m_delay);
      case (e)
        3:       r = 32768;
        2:       r = ($urandom_range(0, 1) != 0) ? 32767 : 0;
        1:       r = ($urandom_range(0, 1) != 0) ? -1 : -32768;
        default: r = -32769;
      endcase
      strobe(r, 1'b0);
    end
    chk("slicer_edges_errs", longint'(err_count) - base, 0);

    // error injection with +3A
    base = int'(m_err); n = 0;
    for (int i = 0; i < 10; i++) begin
      if (past_sym(m_delay) != 3) n++;
      strobe(49152, 1'b0);
    end
    chk("inject_errs", longint'(err_count) - base, n);
    chk("inject_locked", longint'(locked), 1);

    // clear together with a strobe, then clear alone
    strobe(loop_rx(0), 1'b1);
    chk("clr_strobe_syms", longint'(sym_count), 0);
    chk("clr_strobe_errs", longint'(err_count), 0);
    repeat (5) strobe(loop_rx(0), 1'b0);
    @(negedge clk); clear_accum = 1'b1;
    @(negedge clk); clear_accum = 1'b0;
    m_sym = 0; m_err = 0;
    check_all("clr_idle");

    // constant 0 input drops lock; search resumes from the same delay
    d0 = m_delay;
    for (int i = 0; i < 200 && locked; i++) strobe(0, 1'b0);
    chk("loss_locked", longint'(locked), 0);
    chk("loss_delay", longint'(delay), d0);
    repeat (70) strobe(0, 1'b0);

    // reset in mid-window, then a 5-symbol channel delay
    repeat (7) strobe(loop_rx(0), 1'b0);
    @(negedge clk); reset = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("mid_reset");
    reset = 1'b0;
    repeat (383) strobe(loop_rx(5), 1'b0);
    chk("d5_prelock", longint'(locked), 0);
    strobe(loop_rx(5), 1'b0);
    chk("d5_locked", longint'(locked), 1);
    chk("d5_delay", longint'(delay), 5);

    // randomized mix of clean, corrupted and wrongly-delayed samples
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      strobe(loop_rx(5), ($urandom_range(0, 49) == 0));
      else if (r < 90) strobe(int'($urandom_range(0, 131072)) - 65536, 1'b0);
      else             strobe(loop_rx($urandom_range(0, 15)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
